wb_axi4lite_bridge: RTL and testbench

- Registered Wishbone classic master-side to AXI4-Lite master bridge; one outstanding transaction.
- Sits between a CPU/DMA Wishbone master port and the AXI4-Lite interconnect.
- AXI-legal VALID/READY handshakes: VALID never withdrawn before its handshake; AW and W channels complete independently.
- Decodes RRESP/BRESP into ack or err; a configurable response timeout keeps the Wishbone side from hanging.

---
 rtl/wb_axi4lite_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_wb_axi4lite_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi4lite_bridge.sv
// Wishbone classic slave port to AXI4-Lite master, one outstanding transaction,
// with response decoding and a saturating response timeout.
module wb_axi4lite_bridge #(
   parameter int unsigned DBW        = 32,
   parameter int unsigned ABW        = 32,
   parameter int unsigned TMO_CYCLES = 255,
   parameter logic [3:0]  CACHE      = 4'b0011,
   parameter logic [2:0]  PROT       = 3'b000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wbm_cyc,
   input  logic             wbm_stb,
   input  logic             wbm_we,
   input  logic [DBW/8-1:0] wbm_sel,
   input  logic [ABW-1:0]   wbm_adr,
   input  logic [DBW-1:0]   wbm_dat_o,
   output logic [DBW-1:0]   wbm_dat_i,
   output logic             wbm_ack,
   output logic             wbm_err,
   output logic             busy,
   output logic [ABW-1:0]   araddr,
   output logic [3:0]       arcache,
   output logic [2:0]       arprot,
   output logic             arvalid,
   input  logic             arready,
   input  logic [DBW-1:0]   rdata,
   input  logic [1:0]       rresp,
   input  logic             rvalid,
   output logic             rready,
   output logic [ABW-1:0]   awaddr,
   output logic [3:0]       awcache,
   output logic [2:0]       awprot,
   output logic             awvalid,
   input  logic             awready,
   output logic [DBW-1:0]   wdata,
   output logic [DBW/8-1:0] wstrb,
   output logic             wvalid,
   input  logic             wready,
   input  logic [1:0]       bresp,
   input  logic             bvalid,
   output logic             bready
);

   localparam int unsigned SW = DBW / 8;
   localparam int unsigned TW = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RD_A      = 3'd1;
   localparam logic [2:0] S_RD_D      = 3'd2;
   localparam logic [2:0] S_WR        = 3'd3;
   localparam logic [2:0] S_WR_B      = 3'd4;
   localparam logic [2:0] S_DRAIN     = 3'd5;
   localparam logic [2:0] S_ACK       = 3'd6;
   localparam logic [2:0] S_WAIT_NSTB = 3'd7;

   logic [2:0]     state, state_n;
   logic [ABW-1:0] adr_q, adr_n;
   logic [SW-1:0]  sel_q, sel_n;
   logic [DBW-1:0] dat_q, wdat_n;
   logic [DBW-1:0] rdat_n;
   logic           we_q, we_n;
   logic           abort_q, abort_n;
   logic [TW-1:0]  cnt, cnt_n, cnt_inc;
   logic           tmo_hit, drop;
   logic           arvalid_n, awvalid_n, wvalid_n, rready_n, bready_n;
   logic           ack_n, err_n, busy_n;

   assign araddr  = adr_q;
   assign awaddr  = adr_q;
   assign wdata   = dat_q;
   assign wstrb   = sel_q;
   assign arcache = CACHE;
   assign awcache = CACHE;
   assign arprot  = PROT;
   assign awprot  = PROT;

   // Saturating timeout count; the hit is taken on the value being written so
   // err appears together with the counter reaching TMO_CYCLES.
   assign cnt_inc = (cnt == {TW{1'b1}}) ? cnt : cnt + TW'(1);
   assign tmo_hit = (TMO_CYCLES != 0) && (cnt_inc == TW'(TMO_CYCLES));
   assign drop    = abort_q | ~wbm_cyc;

   always_comb begin
      state_n   = state;
      adr_n     = adr_q;
      sel_n     = sel_q;
      wdat_n    = dat_q;
      rdat_n    = wbm_dat_i;
      we_n      = we_q;
      abort_n   = abort_q;
      cnt_n     = cnt;
      arvalid_n = arvalid;
      awvalid_n = awvalid;
      wvalid_n  = wvalid;
      rready_n  = rready;
      bready_n  = bready;
      ack_n     = 1'b0;
      err_n     = 1'b0;

      case (state)
         S_IDLE: begin
            if (wbm_cyc && wbm_stb) begin
               adr_n   = wbm_adr;
               sel_n   = wbm_sel;
               wdat_n  = wbm_dat_o;
               we_n    = wbm_we;
               abort_n = 1'b0;
               cnt_n   = '0;
               if (wbm_we) begin
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  state_n   = S_WR;
               end else begin
                  arvalid_n = 1'b1;
                  state_n   = S_RD_A;
               end
            end
         end
         S_RD_A: begin
            cnt_n = cnt_inc;
            if (!wbm_cyc) abort_n = 1'b1;
            if (arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = S_RD_D;
            end
            if (tmo_hit) begin
               state_n = S_DRAIN;
               err_n   = ~drop;
            end
         end
         S_RD_D: begin
            cnt_n = cnt_inc;
            if (!wbm_cyc) abort_n = 1'b1;
            if (rvalid) begin
               rready_n = 1'b0;
               rdat_n   = rdata;
               if (drop) begin
                  state_n = S_IDLE;
               end else begin
                  state_n = S_ACK;
                  ack_n   = (rresp == 2'b00);
                  err_n   = (rresp != 2'b00);
               end
            end else if (tmo_hit) begin
               state_n = S_DRAIN;
               err_n   = ~drop;
            end
         end
         S_WR: begin
            cnt_n = cnt_inc;
            if (!wbm_cyc) abort_n = 1'b1;
            awvalid_n = awvalid & ~awready;
            wvalid_n  = wvalid & ~wready;
            if (!awvalid_n && !wvalid_n) begin
               bready_n = 1'b1;
               state_n  = S_WR_B;
            end
            if (tmo_hit) begin
               state_n = S_DRAIN;
               err_n   = ~drop;
            end
         end
         S_WR_B: begin
            cnt_n = cnt_inc;
            if (!wbm_cyc) abort_n = 1'b1;
            if (bvalid) begin
               bready_n = 1'b0;
               if (drop) begin
                  state_n = S_IDLE;
               end else begin
                  state_n = S_ACK;
                  ack_n   = (bresp == 2'b00);
                  err_n   = (bresp != 2'b00);
               end
            end else if (tmo_hit) begin
               state_n = S_DRAIN;
               err_n   = ~drop;
            end
         end
         S_DRAIN: begin
            // Finish whatever phases are outstanding and discard the response.
            if (we_q) begin
               awvalid_n = awvalid & ~awready;
               wvalid_n  = wvalid & ~wready;
               if (bready) begin
                  if (bvalid) begin
                     bready_n = 1'b0;
                     state_n  = S_WAIT_NSTB;
                  end
               end else if (!awvalid_n && !wvalid_n) begin
                  bready_n = 1'b1;
               end
            end else begin
               if (arvalid && arready) begin
                  arvalid_n = 1'b0;
                  rready_n  = 1'b1;
               end
               if (rready && rvalid) begin
                  rready_n = 1'b0;
                  state_n  = S_WAIT_NSTB;
               end
            end
         end
         S_ACK: state_n = S_WAIT_NSTB;
         S_WAIT_NSTB: begin
            if (!wbm_stb || !wbm_cyc) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         adr_q     <= '0;
         sel_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         abort_q   <= 1'b0;
         cnt       <= '0;
         wbm_dat_i <= '0;
         wbm_ack   <= 1'b0;
         wbm_err   <= 1'b0;
         busy      <= 1'b0;
         arvalid   <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         rready    <= 1'b0;
         bready    <= 1'b0;
      end else begin
         state     <= state_n;
         adr_q     <= adr_n;
         sel_q     <= sel_n;
         dat_q     <= wdat_n;
         we_q      <= we_n;
         abort_q   <= abort_n;
         cnt       <= cnt_n;
         wbm_dat_i <= rdat_n;
         wbm_ack   <= ack_n;
         wbm_err   <= err_n;
         busy      <= busy_n;
         arvalid   <= arvalid_n;
         awvalid   <= awvalid_n;
         wvalid    <= wvalid_n;
         rready    <= rready_n;
         bready    <= bready_n;
      end
   end

endmodule

// File: tb/tb_wb_axi4lite_bridge.sv
// Directed self-checking bench for wb_axi4lite_bridge (TMO_CYCLES = 8).
module tb_wb_axi4lite_bridge;

   localparam int unsigned DBW = 32;
   localparam int unsigned ABW = 32;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             wbm_cyc, wbm_stb, wbm_we;
   logic [DBW/8-1:0] wbm_sel;
   logic [ABW-1:0]   wbm_adr;
   logic [DBW-1:0]   wbm_dat_o, wbm_dat_i;
   logic             wbm_ack, wbm_err, busy;
   logic [ABW-1:0]   araddr, awaddr;
   logic [3:0]       arcache, awcache;
   logic [2:0]       arprot, awprot;
   logic             arvalid, arready, rvalid, rready;
   logic [DBW-1:0]   rdata, wdata;
   logic [1:0]       rresp, bresp;
   logic             awvalid, awready, wvalid, wready, bvalid, bready;
   logic [DBW/8-1:0] wstrb;

   int checks = 0;
   int errors = 0;
   int n_arv, n_ack;

   wb_axi4lite_bridge #(
      .DBW(DBW), .ABW(ABW), .TMO_CYCLES(8), .CACHE(4'b0011), .PROT(3'b000)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we), .wbm_sel(wbm_sel),
      .wbm_adr(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_ack(wbm_ack), .wbm_err(wbm_err), .busy(busy),
      .araddr(araddr), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
      .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      wbm_cyc = 1'b0; wbm_stb = 1'b0; wbm_we = 1'b0; wbm_sel = 4'hF;
      wbm_adr = '0; wbm_dat_o = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      tick(); tick();
      chk1("rst_arvalid", arvalid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_ack", wbm_ack, 1'b0);
      chk32("rst_dat", wbm_dat_i, 32'h0);
      chk32("arcache", 32'(arcache), 32'h3);
      rst_i = 1'b0;
      tick();

      // Zero-wait read
      arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b0; wbm_adr = 32'h1000;
      tick();
      chk1("rd_c1_arvalid", arvalid, 1'b1);
      chk32("rd_araddr", araddr, 32'h1000);
      chk1("rd_c1_busy", busy, 1'b1);
      chk1("rd_c1_rready", rready, 1'b0);
      tick();
      chk1("rd_c2_arvalid", arvalid, 1'b0);
      chk1("rd_c2_rready", rready, 1'b1);
      chk1("rd_c2_ack", wbm_ack, 1'b0);
      tick();
      chk1("rd_c3_ack", wbm_ack, 1'b1);
      chk1("rd_c3_err", wbm_err, 1'b0);
      chk32("rd_c3_dat", wbm_dat_i, 32'hDEADBEEF);
      chk1("rd_c3_rready", rready, 1'b0);
      wbm_cyc = 1'b0; wbm_stb = 1'b0; arready = 1'b0; rvalid = 1'b0;
      tick();
      chk1("rd_c4_ack", wbm_ack, 1'b0);
      tick();
      chk1("rd_idle_busy", busy, 1'b0);

      // Write: wready in cycle 2, awready in cycle 4, bvalid in cycle 6
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b1; wbm_adr = 32'h2000;
      wbm_sel = 4'b0101; wbm_dat_o = 32'h11223344;
      tick();
      chk1("wr_c1_awvalid", awvalid, 1'b1);
      chk1("wr_c1_wvalid", wvalid, 1'b1);
      chk32("wr_awaddr", awaddr, 32'h2000);
      chk32("wr_wdata", wdata, 32'h11223344);
      chk32("wr_c1_wstrb", 32'(wstrb), 32'h5);
      tick();
      wready = 1'b1;
      chk1("wr_c2_wvalid", wvalid, 1'b1);
      tick();
      wready = 1'b0;
      chk1("wr_c3_wvalid", wvalid, 1'b0);
      chk1("wr_c3_awvalid", awvalid, 1'b1);
      chk32("wr_c3_wstrb", 32'(wstrb), 32'h5);
      tick();
      awready = 1'b1;
      chk1("wr_c4_awvalid", awvalid, 1'b1);
      chk1("wr_c4_bready", bready, 1'b0);
      tick();
      awready = 1'b0;
      chk1("wr_c5_awvalid", awvalid, 1'b0);
      chk1("wr_c5_bready", bready, 1'b1);
      tick();
      bvalid = 1'b1; bresp = 2'b00;
      chk1("wr_c6_ack", wbm_ack, 1'b0);
      tick();
      bvalid = 1'b0;
      chk1("wr_c7_ack", wbm_ack, 1'b1);
      chk1("wr_c7_err", wbm_err, 1'b0);
      chk1("wr_c7_bready", bready, 1'b0);
      wbm_cyc = 1'b0; wbm_stb = 1'b0;
      tick();
      chk1("wr_c8_ack", wbm_ack, 1'b0);
      tick();
      chk1("wr_idle_busy", busy, 1'b0);

      // Read with SLVERR
      arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE0001; rresp = 2'b10;
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b0; wbm_adr = 32'h3000;
      tick(); tick(); tick();
      chk1("rderr_err", wbm_err, 1'b1);
      chk1("rderr_ack", wbm_ack, 1'b0);
      wbm_cyc = 1'b0; wbm_stb = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
      tick();
      chk1("rderr_err_once", wbm_err, 1'b0);
      tick();

      // Write with DECERR
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b11;
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b1; wbm_adr = 32'h4000;
      tick(); tick(); tick();
      chk1("wrerr_err", wbm_err, 1'b1);
      chk1("wrerr_ack", wbm_ack, 1'b0);
      wbm_cyc = 1'b0; wbm_stb = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      tick(); tick();
      chk1("wrerr_idle_busy", busy, 1'b0);

      // Timeout: arready withheld, err 8 edges after accept, then drain
      rdata = 32'h55555555;
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b0; wbm_adr = 32'h5000;
      tick();
      for (int i = 1; i < 8; i++) begin
         tick();
         chk1("tmo_early_err", wbm_err, 1'b0);
      end
      tick();
      chk1("tmo_err", wbm_err, 1'b1);
      chk1("tmo_ack", wbm_ack, 1'b0);
      chk1("tmo_arvalid", arvalid, 1'b1);
      wbm_cyc = 1'b0; wbm_stb = 1'b0;
      tick();
      chk1("tmo_err_once", wbm_err, 1'b0);
      chk1("tmo_drain_arvalid", arvalid, 1'b1);
      chk1("tmo_drain_busy", busy, 1'b1);
      arready = 1'b1; rvalid = 1'b1;
      tick();
      chk1("drain_arvalid", arvalid, 1'b0);
      chk1("drain_rready", rready, 1'b1);
      tick();
      arready = 1'b0; rvalid = 1'b0;
      chk1("drain_rready_off", rready, 1'b0);
      chk1("drain_no_ack", wbm_ack, 1'b0);
      chk1("drain_no_err", wbm_err, 1'b0);
      chk32("drain_dat_kept", wbm_dat_i, 32'hCAFE0001);
      tick();
      chk1("drain_idle_busy", busy, 1'b0);

      // Held strobe: one transaction only
      arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'b00;
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b0; wbm_adr = 32'h6000;
      n_arv = 0; n_ack = 0;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (arvalid) n_arv++;
         if (wbm_ack) n_ack++;
      end
      chk32("held_ar_count", 32'(n_arv), 32'd1);
      chk32("held_ack_count", 32'(n_ack), 32'd1);
      chk1("held_busy", busy, 1'b1);
      wbm_stb = 1'b0;
      tick();
      chk1("held_release_busy", busy, 1'b0);
      wbm_stb = 1'b1;
      tick();
      chk1("restart_arvalid", arvalid, 1'b1);
      tick(); tick();
      chk1("restart_ack", wbm_ack, 1'b1);
      wbm_cyc = 1'b0; wbm_stb = 1'b0; arready = 1'b0; rvalid = 1'b0;
      tick(); tick();

      // cyc dropped mid-read: completes on AXI, silent on Wishbone, straight to IDLE
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b0; wbm_adr = 32'h7000;
      tick();
      wbm_cyc = 1'b0; wbm_stb = 1'b0; arready = 1'b1; rvalid = 1'b1;
      tick();
      chk1("abort_rready", rready, 1'b1);
      tick();
      arready = 1'b0; rvalid = 1'b0;
      chk1("abort_no_ack", wbm_ack, 1'b0);
      chk1("abort_no_err", wbm_err, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      tick();

      // Asynchronous reset in the middle of a write
      wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = 1'b1; wbm_adr = 32'h8000;
      tick();
      chk1("rstwr_awvalid_pre", awvalid, 1'b1);
      #2 rst_i = 1'b1;
      #1;
      chk1("rstwr_awvalid", awvalid, 1'b0);
      chk1("rstwr_wvalid", wvalid, 1'b0);
      chk1("rstwr_bready", bready, 1'b0);
      chk1("rstwr_busy", busy, 1'b0);
      wbm_cyc = 1'b0; wbm_stb = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();
      chk1("rstwr_idle_busy", busy, 1'b0);
      chk1("rstwr_idle_awvalid", awvalid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
